handshake_fifo: RTL

Parametrised elastic buffer on the valid/ready handshake, placed between a handshake master and a handshake slave.
- Generalises the single-beat, always-ready link to configurable data width and buffer depth.
- Absorbs downstream backpressure and reports fill level and almost-full/almost-empty status.
- Used at every handshake boundary that needs decoupling or rate smoothing.

---
 rtl/handshake_pkg.sv | 21 ++
 rtl/handshake_fifo_mem.sv | 40 ++++
 rtl/handshake_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/handshake_pkg.sv
// ---------------------------------------------------------------------------
// handshake_pkg
// Shared definitions for the valid/ready handshake blocks.
//   DEF_DATA_BITS / DEF_DEPTH : default payload width and buffer depth
//   cnt_bits(depth)           : width of an occupancy counter that must be
//                               able to hold the values 0..depth inclusive
//   hs_count_t                : occupancy type for default-sized blocks
// ---------------------------------------------------------------------------
package handshake_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_DEPTH     = 4;

  // Occupancy needs depth+1 distinct values (empty through full).
  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [cnt_bits(DEF_DEPTH)-1:0] hs_count_t;

endpackage : handshake_pkg

// File: rtl/handshake_fifo_mem.sv
// ---------------------------------------------------------------------------
// handshake_fifo_mem
// DEPTH x DATA_BITS storage array for handshake_fifo.
// Ports:
//   clk   : clock, write happens on posedge
//   we    : write enable
//   waddr : write address (0..DEPTH-1)
//   wdata : write data
//   raddr : read address (0..DEPTH-1)
//   rdata : asynchronous read data, mem[raddr]
// The array has no reset: contents are only meaningful where the owning
// FIFO's pointers say they are.
// ---------------------------------------------------------------------------
module handshake_fifo_mem
  import handshake_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem_r [DEPTH];

  // Single write port; addresses beyond DEPTH-1 are never generated.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule : handshake_fifo_mem

// File: rtl/handshake_fifo.sv
// ---------------------------------------------------------------------------
// handshake_fifo
// Elastic buffer between a valid/ready master (s_*) and slave (m_*).
// Ports:
//   clk          : single clock, all state updates on posedge
//   rstn         : synchronous active-low reset
//   s_valid/s_ready/s_data : upstream handshake (beat accepted when both high)
//   m_valid/m_ready/m_data : downstream handshake (beat leaves when both high)
//   count        : current occupancy, 0..DEPTH
//   almost_full  : count >= AFULL_LVL
//   almost_empty : count <= AEMPTY_LVL
// Build option:
//   HANDSHAKE_FIFO_BYPASS_EN : when empty, s_* is forwarded combinationally to
//   m_*; a beat taken downstream in that same cycle is never stored.
//   Undefined (default): one-cycle latency, no combinational s_* -> m_* path.
// s_ready depends only on registered occupancy, so no path from m_ready.
// ---------------------------------------------------------------------------
module handshake_fifo
  import handshake_pkg::*;
#(
  parameter  int DATA_BITS  = DEF_DATA_BITS,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int AFULL_LVL  = DEPTH - 1,
  parameter  int AEMPTY_LVL = 1,
  localparam int CNT_BITS   = cnt_bits(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic [CNT_BITS-1:0]  count,
  output logic                 almost_full,
  output logic                 almost_empty
);

  localparam int                  PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_BITS-1:0] LAST_PTR = PTR_BITS'(DEPTH - 1);
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] ZERO_CNT = {CNT_BITS{1'b0}};
  localparam logic [PTR_BITS-1:0] ZERO_PTR = {PTR_BITS{1'b0}};

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    logic [PTR_BITS-1:0] n;
    if (p == LAST_PTR) begin
      n = ZERO_PTR;
    end else begin
      n = p + PTR_BITS'(1'b1);
    end
    return n;
  endfunction

  logic [PTR_BITS-1:0]  wr_ptr_r;
  logic [PTR_BITS-1:0]  rd_ptr_r;
  logic [CNT_BITS-1:0]  count_r;

  logic [PTR_BITS-1:0]  wr_ptr_next_s;
  logic [PTR_BITS-1:0]  rd_ptr_next_s;
  logic [CNT_BITS-1:0]  cnt_next_s;
  logic                 empty_s;
  logic                 s_ready_s;
  logic                 push_s;
  logic                 bypass_s;
  logic                 wr_en_s;
  logic                 rd_en_s;
  logic                 m_valid_s;
  logic [DATA_BITS-1:0] m_data_s;
  logic [DATA_BITS-1:0] rdata_s;

  handshake_fifo_mem #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .ADDR_BITS (PTR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata (s_data),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  // Handshake decode: acceptance, bypass, storage write and storage read.
  always_comb begin
    empty_s   = (count_r == ZERO_CNT);
    s_ready_s = (count_r != FULL_CNT);
    push_s    = s_valid && s_ready_s;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    // Empty buffer: present the upstream beat directly; if it is taken now
    // it never touches storage.
    bypass_s  = empty_s && s_valid && m_ready;
    if (empty_s) begin
      m_valid_s = s_valid;
      m_data_s  = s_data;
    end else begin
      m_valid_s = 1'b1;
      m_data_s  = rdata_s;
    end
`else
    bypass_s  = 1'b0;
    m_valid_s = !empty_s;
    m_data_s  = rdata_s;
`endif
    wr_en_s   = push_s && !bypass_s;
    // Only a stored beat advances the read side.
    rd_en_s   = !empty_s && m_ready;
  end

  // Next occupancy and pointer values.
  always_comb begin
    cnt_next_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   cnt_next_s = count_r + CNT_BITS'(1'b1);
      2'b01:   cnt_next_s = count_r - CNT_BITS'(1'b1);
      default: cnt_next_s = count_r;
    endcase
    if (wr_en_s) begin
      wr_ptr_next_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (rd_en_s) begin
      rd_ptr_next_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
  end

  // Pointer and occupancy state; reset discards contents but not storage.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r <= ZERO_PTR;
      rd_ptr_r <= ZERO_PTR;
      count_r  <= ZERO_CNT;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= cnt_next_s;
    end
  end

  assign s_ready      = s_ready_s;
  assign m_valid      = m_valid_s;
  assign m_data       = m_data_s;
  assign count        = count_r;
  assign almost_full  = (int'(count_r) >= AFULL_LVL);
  assign almost_empty = (int'(count_r) <= AEMPTY_LVL);

endmodule : handshake_fifo
